// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg
// Shared definitions for the adder arbiter: the transaction FSM state
// encoding and the default operand width / requester count.
package adder_arbiter_pkg;

  localparam int DEFAULT_INPUT_WIDTH = 4;
  localparam int DEFAULT_NUM_REQ     = 4;

  // One transaction walks IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin grant. The search starts one position past
// the last granted index and wraps, so the last winner has lowest
// priority on the next grant.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the last granted requester
//   grant - one-hot grant (all zero when nothing is requested)
//   idx   - binary index of the granted requester
//   any   - at least one request is present
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the N candidates in priority order; the first requesting one wins.
  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Shares one external registered adder between NUM_REQ requesters. A
// round-robin grant accepts one operation, the operands are issued to the
// adder for one cycle, the registered sum is captured, and the result is
// held for the owning requester until it accepts it.
// Ports:
//   clk, rst            - clock (rising edge) and async active-high reset
//   req_valid/a/b       - per-requester request and packed operands
//   req_ready           - one-hot accept strobe (IDLE only)
//   rsp_valid, rsp_sum  - one-hot result valid and the full-width sum
//   rsp_ready           - per-requester result acceptance
//   add_a, add_b, add_en, add_sum - connection to the shared adder
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int INPUT_WIDTH = DEFAULT_INPUT_WIDTH,
  parameter int NUM_REQ     = DEFAULT_NUM_REQ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [INPUT_WIDTH:0]           rsp_sum,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [INPUT_WIDTH-1:0]         add_a,
  output logic [INPUT_WIDTH-1:0]         add_b,
  output logic                           add_en,
  input  logic [INPUT_WIDTH:0]           add_sum
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                 state_q;
  state_t                 state_d;
  logic [IDX_W-1:0]       last_q;
  logic [INPUT_WIDTH-1:0] op_a_q;
  logic [INPUT_WIDTH-1:0] op_b_q;
  logic [INPUT_WIDTH:0]   result_q;
  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (last_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // The adder sees the latched operands at all times; only add_en marks
  // the cycle in which they are meant to be summed.
  assign add_a   = op_a_q;
  assign add_b   = op_b_q;
  assign rsp_sum = result_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // last_q doubles as round-robin pointer and owner of the transaction in
  // flight. Its reset value makes requester 0 the first candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= IDX_W'(NUM_REQ - 1);
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      if (state_q == ST_IDLE && grant_any) begin
        last_q <= grant_idx;
        op_a_q <= req_a[grant_idx*INPUT_WIDTH +: INPUT_WIDTH];
        op_b_q <= req_b[grant_idx*INPUT_WIDTH +: INPUT_WIDTH];
      end
      if (state_q == ST_CAPTURE) begin
        result_q <= add_sum;
      end
    end
  end

  // Next-state and strobe outputs. Only the owner's rsp_ready can end RESP.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    add_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        add_en  = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[last_q] = 1'b1;
        if (rsp_ready[last_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
// Directed self-checking bench for adder_arbiter with a behavioural
// registered adder standing in for the shared adder.
module tb_adder_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W:0]     rsp_sum;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_en;
  logic [W:0]     add_sum;

  int checks;
  int errors;

  adder_arbiter #(
    .INPUT_WIDTH (W),
    .NUM_REQ     (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_en    (add_en),
    .add_sum   (add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared registered adder, reset by the same rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) add_sum <= '0;
    else if (add_en) add_sum <= {1'b0, add_a} + {1'b0, add_b};
  end

  // Advance to the next cycle; inputs set here apply to that cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    step();
    checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (rsp_sum !== 5'd0) begin errors++; $display("[TB] FAIL reset_rsp_sum got %0d exp 0", rsp_sum); end
    checks++; if ({add_en, add_a, add_b} !== 9'd0) begin errors++; $display("[TB] FAIL reset_adder got en=%b a=%0d b=%0d exp 0", add_en, add_a, add_b); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 4'd3, 4'd4); req_valid = 4'b0001; rsp_ready = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_accept got %b exp 0001", req_ready); end
    checks++; if (add_en !== 1'b0) begin errors++; $display("[TB] FAIL single_en_c0 got %b exp 0", add_en); end
    step(); req_valid = '0;
    checks++; if ({add_en, add_a, add_b} !== {1'b1, 4'd3, 4'd4}) begin errors++; $display("[TB] FAIL single_issue got en=%b a=%0d b=%0d exp 1/3/4", add_en, add_a, add_b); end
    step();
    checks++; if (add_en !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("[TB] FAIL single_capture got en=%b rsp_valid=%b exp 0/0000", add_en, rsp_valid); end
    step();
    checks++; if (rsp_valid !== 4'b0001 || rsp_sum !== 5'd7) begin errors++; $display("[TB] FAIL single_resp got %b/%0d exp 0001/7", rsp_valid, rsp_sum); end
    step();
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("[TB] FAIL single_done got %b exp 0000", rsp_valid); end
    checks++; if (add_a !== 4'd3) begin errors++; $display("[TB] FAIL single_hold_a got %0d exp 3", add_a); end
  endtask

  task automatic test_contention();
    logic [W:0] exp_sum [N] = '{5'd6, 5'd8, 5'd10, 5'd12};
    do_reset();
    set_op(0, 4'd1, 4'd5); set_op(1, 4'd2, 4'd6); set_op(2, 4'd3, 4'd7); set_op(3, 4'd4, 4'd8);
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (req_ready !== 4'(1 << (k % N))) begin errors++; $display("[TB] FAIL rr_grant_%0d got %b exp %b", k, req_ready, 4'(1 << (k % N))); end
      step();
      checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL rr_no_grant_%0d got %b exp 0000", k, req_ready); end
      step(); step();
      checks++; if (rsp_valid !== 4'(1 << (k % N)) || rsp_sum !== exp_sum[k % N]) begin errors++; $display("[TB] FAIL rr_resp_%0d got %b/%0d exp %b/%0d", k, rsp_valid, rsp_sum, 4'(1 << (k % N)), exp_sum[k % N]); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    set_op(3, 4'd15, 4'd15); req_valid = 4'b1000; rsp_ready = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL ovf_accept got %b exp 1000", req_ready); end
    step(); req_valid = '0;
    step(); step();
    checks++; if (rsp_valid !== 4'b1000 || rsp_sum !== 5'b11110) begin errors++; $display("[TB] FAIL ovf_sum got %b/%0d exp 1000/30", rsp_valid, rsp_sum); end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(1, 4'd9, 4'd8); set_op(0, 4'd1, 4'd1); req_valid = 4'b0010; rsp_ready = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_accept got %b exp 0010", req_ready); end
    step(); req_valid = 4'b0011;
    step(); step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 4'b0010 || rsp_sum !== 5'd17 || req_ready !== 4'b0 || add_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_%0d got v=%b s=%0d rdy=%b en=%b exp 0010/17/0000/0", c, rsp_valid, rsp_sum, req_ready, add_en); end
      step();
    end
    rsp_ready = 4'b0010;
    #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release_cycle got %b exp 0010", rsp_valid); end
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bp_next_grant got %b exp 0001", req_ready); end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_capture();
    do_reset();
    set_op(0, 4'd5, 4'd6); set_op(2, 4'd7, 4'd1); req_valid = 4'b0001; rsp_ready = 4'b1111;
    step(); req_valid = '0;
    step();
    rst = 1'b1;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_sum, add_en, add_a, add_b} !== 22'd0) begin errors++; $display("[TB] FAIL rstcap_outputs got rdy=%b v=%b s=%0d en=%b a=%0d b=%0d exp 0", req_ready, rsp_valid, rsp_sum, add_en, add_a, add_b); end
    step();
    checks++; if (rsp_valid !== 4'b0 || rsp_sum !== 5'd0) begin errors++; $display("[TB] FAIL rstcap_no_rsp got %b/%0d exp 0000/0", rsp_valid, rsp_sum); end
    rst = 1'b0; req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL rstcap_regrant got %b exp 0100", req_ready); end
    step(); req_valid = '0;
    step(); step();
    checks++; if (rsp_valid !== 4'b0100 || rsp_sum !== 5'd8) begin errors++; $display("[TB] FAIL rstcap_resp got %b/%0d exp 0100/8", rsp_valid, rsp_sum); end
    step();
  endtask

  task automatic test_wrong_port();
    do_reset();
    set_op(2, 4'd2, 4'd13); req_valid = 4'b0100; rsp_ready = 4'b0010;
    step(); req_valid = '0;
    step(); step();
    for (int c = 0; c < 3; c++) begin
      checks++; if (rsp_valid !== 4'b0100 || rsp_sum !== 5'd15) begin errors++; $display("[TB] FAIL wrong_port_%0d got %b/%0d exp 0100/15", c, rsp_valid, rsp_sum); end
      step();
    end
    rsp_ready = 4'b0100;
    step();
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("[TB] FAIL wrong_port_release got %b exp 0000", rsp_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_backpressure();
    test_reset_capture();
    test_wrong_port();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 4: operand width, matching the shared registered adder.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters; legal range 2..8.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_a  input  NUM_REQ*INPUT_WIDTH  operand A, requester i in slice [i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-007 SHALL have port req_b  input  NUM_REQ*INPUT_WIDTH  operand B, same slicing.
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-009 SHALL have port rsp_valid  output  NUM_REQ  one-hot result-valid to the owning requester.
REQ-010 SHALL have port rsp_sum  output  INPUT_WIDTH+1  result, meaningful only while any rsp_valid bit is high.
REQ-011 SHALL have port rsp_ready  input  NUM_REQ  per-requester result acceptance.
REQ-012 SHALL have port add_a, add_b  output  INPUT_WIDTH each  operands to the shared adder.
REQ-013 SHALL have port add_en  output  1  adder enable.
REQ-014 SHALL have port add_sum  input  INPUT_WIDTH+1  registered adder output.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
REQ-016 IDLE: if any req_valid, SHALL grant one requester by round-robin, assert req_ready for that requester only for that cycle, latch its operands and index, go to ISSUE; otherwise stay.
REQ-017 Round-robin: search SHALL start at (last granted index + 1) mod NUM_REQ; pointer updates only on grant.
REQ-018 ISSUE: SHALL drive add_a/add_b from latched operands and assert add_en for exactly one cycle; go to CAPTURE.
REQ-019 CAPTURE: SHALL register add_sum into the result register; add_en low; go to RESP.
REQ-020 RESP: SHALL hold rsp_valid[granted] high and rsp_sum stable until rsp_ready[granted] is high at a rising edge, then go to IDLE.
REQ-021 rsp_ready bits of non-granted requesters SHALL be ignored.
REQ-022 Latency: accept at cycle N SHALL give rsp_valid first high in cycle N+3; minimum issue interval 4 cycles.
REQ-023 add_en SHALL be low in all states except ISSUE; add_a/add_b SHALL hold latched values outside ISSUE.
REQ-024 rsp_sum SHALL be the full INPUT_WIDTH+1-bit sum; no truncation, no saturation.
REQ-025 req_valid deasserted by a requester without acceptance SHALL not be an error; requests are not queued.
REQ-026 A requester may hold req_valid high during its own RESP; it SHALL become eligible again only in IDLE, after the others per round-robin.

Reset
REQ-027 On rst: state IDLE, RR pointer such that requester 0 has highest priority, req_ready 0, rsp_valid 0, rsp_sum 0, add_en 0, add_a/add_b 0.
REQ-028 Reset mid-transaction SHALL abandon the operation with no response; the adder shares the same rst.

Structure
REQ-029 Shared package SHALL hold the FSM state enum and default NUM_REQ/INPUT_WIDTH constants.
REQ-030 Round-robin grant logic SHALL be one sub-module, rr_arbiter (request vector, pointer in, one-hot grant and index out).
REQ-031 The shared adder SHALL be instantiated outside this block; connection only through add_* ports.

Verification
REQ-032 Single: req_valid=0001, A=3, B=4, rsp_ready=1 -> req_ready[0] at cycle 0, add_en at cycle 1, rsp_valid=0001 with rsp_sum=7 at cycle 3.
REQ-033 Contention: req_valid=1111 held, each rsp_ready=1 -> grant order 0,1,2,3,0, each 4 cycles apart.
REQ-034 Overflow: A=15, B=15 -> rsp_sum=30 (5'b11110).
REQ-035 Backpressure: rsp_ready[1]=0 for 5 cycles in RESP -> rsp_valid[1] and rsp_sum stable, no new grant, add_en stays 0.
REQ-036 Reset in CAPTURE -> all outputs 0 next cycle, no rsp_valid; then req_valid=0100 -> granted in first IDLE cycle after rst release.
REQ-037 Wrong-port ready: rsp_ready=0010 while owner is requester 2 -> stays in RESP.
